// File: rtl/nxr2_seq_cmp.sv
// Two-requester, bit-serial equality comparator sharing one 1-bit XNOR datapath.
// Define NXR2_SEQ_HAMMING_EN to add the mismatch counter and the dist output.
module nxr2_seq_cmp #(
  parameter int WIDTH = 8
) (
  input  logic             ck,
  input  logic             nrst,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             busy,
  output logic             done,
  output logic             eq
`ifdef NXR2_SEQ_HAMMING_EN
  ,
  output logic [$clog2(WIDTH+1)-1:0] dist
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             match_q, match_d;
  logic             gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic             busy_q, busy_d, done_q, done_d, eq_q, eq_d;
  logic             last_q, last_d;
  logic             bit_eq;
  logic             pick0;

`ifdef NXR2_SEQ_HAMMING_EN
  localparam int DW = $clog2(WIDTH + 1);
  logic [DW-1:0] mism_q, mism_d, dist_q, dist_d;
  logic [DW-1:0] mism_inc;
  assign mism_inc = {{(DW-1){1'b0}}, ~bit_eq};
`endif

  // The one shared compare element: LSB of each shift register.
  assign bit_eq = ~(a_q[0] ^ b_q[0]);
  // Round-robin: req0 wins a tie only if requester 1 was served last.
  assign pick0  = req0 & (~req1 | last_q);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    match_d = match_q;
    gnt0_d  = gnt0_q;
    gnt1_d  = gnt1_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    eq_d    = eq_q;
    last_d  = last_q;
`ifdef NXR2_SEQ_HAMMING_EN
    mism_d  = mism_q;
    dist_d  = dist_q;
`endif
    case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          state_d = SHIFT;
          a_d     = pick0 ? a0 : a1;
          b_d     = pick0 ? b0 : b1;
          cnt_d   = '0;
          match_d = 1'b1;
          gnt0_d  = pick0;
          gnt1_d  = ~pick0;
          busy_d  = 1'b1;
`ifdef NXR2_SEQ_HAMMING_EN
          mism_d  = '0;
`endif
        end
      end
      SHIFT: begin
        match_d = match_q & bit_eq;
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        cnt_d   = cnt_q + CW'(1);
`ifdef NXR2_SEQ_HAMMING_EN
        mism_d  = mism_q + mism_inc;
`endif
        if (cnt_q == LAST_BIT) begin
          state_d = DONE;
          done_d  = 1'b1;
          eq_d    = match_q & bit_eq;
`ifdef NXR2_SEQ_HAMMING_EN
          dist_d  = mism_q + mism_inc;
`endif
        end
      end
      DONE: begin
        state_d = IDLE;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        busy_d  = 1'b0;
        last_d  = gnt1_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ck or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      eq_q    <= 1'b0;
      last_q  <= 1'b1;
`ifdef NXR2_SEQ_HAMMING_EN
      dist_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      eq_q    <= eq_d;
      last_q  <= last_d;
`ifdef NXR2_SEQ_HAMMING_EN
      dist_q  <= dist_d;
`endif
    end
  end

  // Operand shifters and running flags are always (re)initialised at capture.
  always_ff @(posedge ck) begin
    a_q     <= a_d;
    b_q     <= b_d;
    match_q <= match_d;
`ifdef NXR2_SEQ_HAMMING_EN
    mism_q  <= mism_d;
`endif
  end

  assign gnt0 = gnt0_q;
  assign gnt1 = gnt1_q;
  assign busy = busy_q;
  assign done = done_q;
  assign eq   = eq_q;
`ifdef NXR2_SEQ_HAMMING_EN
  assign dist = dist_q;
`endif

endmodule

// File: doc/nxr2_seq_cmp.md
NXR2_SEQ_CMP -- requirements
Module: nxr2_seq_cmp

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 2..32).
REQ-002 SHALL have port ck, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port nrst, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have ports req0 and req1, inputs, 1 bit each: compare requests from requester 0 and requester 1.
REQ-005 SHALL have ports a0 and b0, inputs, WIDTH bits each: operand pair for requester 0.
REQ-006 SHALL have ports a1 and b1, inputs, WIDTH bits each: operand pair for requester 1.
REQ-007 SHALL have ports gnt0 and gnt1, outputs, 1 bit each: the shared XNOR compare datapath is owned by that requester.
REQ-008 SHALL have port busy, output, 1 bit: a compare is in progress (SHIFT or DONE state).
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse; the result is valid.
REQ-010 SHALL have port eq, output, 1 bit: the last compare found all bits equal.
REQ-011 SHALL have port dist, output, $clog2(WIDTH+1) bits, present only with NXR2_SEQ_HAMMING_EN: mismatch count.

Function
REQ-012 SHALL implement FSM states IDLE, SHIFT and DONE; all outputs are registered.
REQ-013 In IDLE with req0|req1 high, the next edge SHALL select a winner, load the winner's a/b into shift registers, clear bit counter cnt to 0, set the match flag to 1 and enter SHIFT.
REQ-014 Arbitration SHALL be round-robin: on simultaneous requests, the requester not served last wins; a lone request always wins.
REQ-015 gntN SHALL be high from the edge that enters SHIFT through the end of DONE; at most one of gnt0/gnt1 is high at any time.
REQ-016 Each SHIFT edge SHALL evaluate one bit pair, LSB first, through a single 1-bit XNOR; match &= xnor; then shift both registers right and increment cnt.
REQ-017 The SHIFT edge that evaluates cnt==WIDTH-1 SHALL enter DONE; done SHALL rise exactly WIDTH cycles after the capture edge.
REQ-018 In DONE, done=1 for exactly one cycle, and eq SHALL take the final match value; the next edge SHALL return to IDLE and record the winner as last-served.
REQ-019 eq (and dist) SHALL hold their value until the next DONE; they are not cleared on IDLE or capture.
REQ-020 Request inputs and operands SHALL be ignored outside IDLE; a deasserted request mid-operation still completes and pulses done.
REQ-021 A request held high through DONE SHALL be re-arbitrated in the following IDLE cycle (minimum one IDLE cycle between operations).
REQ-022 Operand changes after the capture edge SHALL NOT affect the result.

Reset
REQ-023 nrst low SHALL immediately force state=IDLE, gnt0=gnt1=0, busy=0, done=0, eq=0, cnt=0, dist=0, and last-served=1 (so req0 wins the first tie).
REQ-024 Reset asserted mid-operation SHALL abort the operation with no done pulse; after release, the first edge with a request starts a fresh capture.

Configuration
REQ-025 Macro NXR2_SEQ_HAMMING_EN defined: a mismatch counter SHALL increment on each SHIFT bit where the XNOR is 0; it is cleared at capture and copied to dist in DONE.
REQ-026 NXR2_SEQ_HAMMING_EN undefined: the dist port and counter SHALL be absent; all other behaviour is identical.

Verification
REQ-027 WIDTH=8, req0=1, a0=b0=8'hA5 -> gnt0 high; done pulses 8 cycles after capture; eq=1; dist=0.
REQ-028 req1=1, a1=8'h3C, b1=8'h3D -> eq=0; dist=1; gnt1 high for 9 cycles (SHIFT through DONE).
REQ-029 After reset, req0=req1=1 held -> grants alternate 0,1,0,1 across consecutive operations.
REQ-030 nrst pulsed low 3 cycles after capture -> outputs cleared at once; no done; a new request then completes normally.
REQ-031 req0 dropped and a0 changed one cycle after capture, a0=8'hFF, b0=8'h00 -> done still pulses; eq=0; dist=8.
